// File: rtl/stream_serializer.sv
// stream_serializer: wide-to-narrow valid/ready serializer, LSB slice first; define SERIALIZER_LAST_EN to add last_o
module stream_serializer #(
  parameter int InWidth  = 32,
  parameter int OutWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [InWidth-1:0]  data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [OutWidth-1:0] data_o,
  output logic                busy_o
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                last_o
`endif
);
  localparam int NumBeats = InWidth / OutWidth;
  localparam int CntW = NumBeats > 1 ? $clog2(NumBeats) : 1;
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e state_q, state_d;
  logic [InWidth-1:0] shift_q, shift_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic last_beat, load;
  if (OutWidth < 1 || InWidth % OutWidth != 0 || NumBeats < 1) begin : g_cfg_err
    $error("stream_serializer: InWidth must be a non-zero multiple of OutWidth");
  end
  assign last_beat = cnt_q == CntW'(NumBeats - 1);
  assign valid_o = state_q == SHIFT;
  assign busy_o = valid_o;
  assign data_o = valid_o ? shift_q[OutWidth-1:0] : '0;
`ifdef SERIALIZER_LAST_EN
  assign last_o = valid_o & last_beat;
`endif
  // A new word may only enter on the cycle the final beat leaves, giving bubble-free back-to-back words
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    ready_o = ~clear_i & (valid_o ? last_beat & ready_i : 1'b1);
    load = valid_i & ready_o;
    if (clear_i) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d = '0;
    end else if (load) begin
      state_d = SHIFT;
      shift_d = data_i;
      cnt_d = '0;
    end else if (valid_o & ready_i) begin
      state_d = last_beat ? IDLE : SHIFT;
      shift_d = last_beat ? '0 : shift_q >> OutWidth;
      cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
